// File: rtl/dmac_fifo_pkg.sv
// Shared definitions for the DMAC parametrised FIFO: state encoding and parameter helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmac_fifo_pkg;

    // Externally visible FSM encoding; code 7 is unused and decodes as illegal.
    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        WR_ERROR = 3'd3,
        READ     = 3'd4,
        RD_ERROR = 3'd5,
        RDWR     = 3'd6
    } state_t;

    localparam logic [2:0] ST_ILLEGAL = 3'd7;

    // Ceiling log2, used to derive the pointer width from DEPTH at elaboration.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmac_fifo_param_ns.sv
// Next-state and operation decode for the DMAC FIFO control FSM (purely combinational).
// Latency: 0 cycles; outputs settle from inputs within the same cycle.
// Backpressure: none; a request that cannot be honoured raises wr_err_n/rd_err_n instead.
//
// Ports:
//   wr_en, rd_en      requests from the writer / reader
//   state             current registered FSM state
//   data_count        current registered fill level
//   next_state        state to load on the next edge
//   do_wr, do_rd      perform the memory write / read on the next edge
//   wr_err_n, rd_err_n  error strobe values to register on the next edge
module dmac_fifo_param_ns #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [2:0]    state,
    input  logic [CW-1:0] data_count,
    output logic [2:0]    next_state,
    output logic          do_wr,
    output logic          do_rd,
    output logic          wr_err_n,
    output logic          rd_err_n
);
    import dmac_fifo_pkg::*;

    logic cnt_empty;
    logic cnt_full;
    logic state_legal;

    assign cnt_empty   = (data_count == '0);
    assign cnt_full    = (data_count == CW'(DEPTH));
    // The decode is the same from every legal state; only the unused code is special.
    assign state_legal = (state != ST_ILLEGAL);

    always_comb begin
        next_state = INIT;
        do_wr      = 1'b0;
        do_rd      = 1'b0;
        wr_err_n   = 1'b0;
        rd_err_n   = 1'b0;

        if (state_legal) begin
            if (wr_en && rd_en) begin
                if (cnt_empty) begin
                    // Nothing to read yet: the write still goes ahead, the read is rejected.
                    next_state = WRITE;
                    do_wr      = 1'b1;
                    rd_err_n   = 1'b1;
                end else if (cnt_full) begin
                    // No room: the read still goes ahead, the write is rejected.
                    next_state = READ;
                    do_rd      = 1'b1;
                    wr_err_n   = 1'b1;
                end else begin
                    next_state = RDWR;
                    do_wr      = 1'b1;
                    do_rd      = 1'b1;
                end
            end else if (wr_en) begin
                if (cnt_full) begin
                    next_state = WR_ERROR;
                    wr_err_n   = 1'b1;
                end else begin
                    next_state = WRITE;
                    do_wr      = 1'b1;
                end
            end else if (rd_en) begin
                if (cnt_empty) begin
                    next_state = RD_ERROR;
                    rd_err_n   = 1'b1;
                end else begin
                    next_state = READ;
                    do_rd      = 1'b1;
                end
            end else begin
                next_state = NO_OP;
            end
        end
    end

endmodule

// File: rtl/dmac_fifo_param.sv
// Parametrised single-clock FIFO between the DMAC fetch engine (writer) and store engine (reader).
// Latency: 1 cycle write-to-count, 1 cycle read-to-d_out (d_out valid with rd_ack).
// Backpressure: no stall; writes when full / reads when empty are dropped and flagged via wr_err / rd_err.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   wr_en, d_in       write request and data
//   rd_en, d_out      read request and registered read data
//   state             current FSM state (INIT..RDWR)
//   data_count        entries held, 0..DEPTH
//   full, empty, almost_full, almost_empty   level flags decoded from data_count
//   wr_ack, wr_err, rd_ack, rd_err           one-cycle registered outcome strobes
module dmac_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic                               rd_en,
    input  logic [DATA_WIDTH-1:0]              d_in,
    output logic [DATA_WIDTH-1:0]              d_out,
    output logic [2:0]                         state,
    output logic [dmac_fifo_pkg::clog2(DEPTH):0] data_count,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               wr_ack,
    output logic                               wr_err,
    output logic                               rd_ack,
    output logic                               rd_err
);
    import dmac_fifo_pkg::*;

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    state_t                state_q;

    logic [2:0] next_state;
    logic       do_wr;
    logic       do_rd;
    logic       wr_err_n;
    logic       rd_err_n;

    dmac_fifo_param_ns #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ns (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .state      (state_q),
        .data_count (data_count),
        .next_state (next_state),
        .do_wr      (do_wr),
        .do_rd      (do_rd),
        .wr_err_n   (wr_err_n),
        .rd_err_n   (rd_err_n)
    );

    // Control, pointers, count and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            head       <= '0;
            tail       <= '0;
            data_count <= '0;
            d_out      <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            state_q <= state_t'(next_state);
            // Strobes are recomputed every cycle so they stay high across back-to-back events.
            wr_ack  <= do_wr;
            rd_ack  <= do_rd;
            wr_err  <= wr_err_n;
            rd_err  <= rd_err_n;

            if (do_wr) begin
                tail <= tail + AW'(1);
            end
            if (do_rd) begin
                d_out <= mem[head];
                head  <= head + AW'(1);
            end

            // A simultaneous read and write leaves the level unchanged.
            case ({do_wr, do_rd})
                2'b10:   data_count <= data_count + CW'(1);
                2'b01:   data_count <= data_count - CW'(1);
                default: data_count <= data_count;
            endcase
        end
    end

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            mem[tail] <= d_in;
        end
    end

    assign state        = state_q;
    assign full         = (data_count == CW'(DEPTH));
    assign empty        = (data_count == '0);
    assign almost_full  = (data_count >= CW'(AF_LEVEL));
    assign almost_empty = (data_count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_dmac_fifo_param.sv
module tb_dmac_fifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic [2:0]    state;
    logic [3:0]    data_count;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;

    // Standalone decode instance used to reach the unused state code.
    logic       t_wr, t_rd;
    logic [2:0] t_state;
    logic [3:0] t_cnt;
    logic [2:0] t_next;
    logic       t_do_wr, t_do_rd, t_wr_err, t_rd_err;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue plus the expected registered outputs.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic [2:0]    m_state;
    bit            m_wa, m_we, m_ra, m_re;

    dmac_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .d_in         (d_in),
        .d_out        (d_out),
        .state        (state),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err)
    );

    dmac_fifo_param_ns #(
        .DEPTH (DEPTH),
        .CW    (4)
    ) u_ns_chk (
        .wr_en      (t_wr),
        .rd_en      (t_rd),
        .state      (t_state),
        .data_count (t_cnt),
        .next_state (t_next),
        .do_wr      (t_do_wr),
        .do_rd      (t_do_rd),
        .wr_err_n   (t_wr_err),
        .rd_err_n   (t_rd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Advance the model by one clock using the behavioural rules of the FIFO.
    task automatic model(input bit w, input bit r, input logic [DW-1:0] d, input bit rst);
        int n;
        n = mq.size();
        m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
        if (rst) begin
            mq.delete();
            m_dout  = '0;
            m_state = 3'd0;
        end else if (w && r) begin
            if (n == 0) begin
                mq.push_back(d); m_state = 3'd2; m_wa = 1; m_re = 1;
            end else if (n == DEPTH) begin
                m_dout = mq.pop_front(); m_state = 3'd4; m_ra = 1; m_we = 1;
            end else begin
                m_dout = mq.pop_front(); mq.push_back(d); m_state = 3'd6; m_wa = 1; m_ra = 1;
            end
        end else if (w) begin
            if (n == DEPTH) begin
                m_state = 3'd3; m_we = 1;
            end else begin
                mq.push_back(d); m_state = 3'd2; m_wa = 1;
            end
        end else if (r) begin
            if (n == 0) begin
                m_state = 3'd5; m_re = 1;
            end else begin
                m_dout = mq.pop_front(); m_state = 3'd4; m_ra = 1;
            end
        end else begin
            m_state = 3'd1;
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".state"},  DW'(state),        DW'(m_state));
        chk({tag, ".count"},  DW'(data_count),   DW'(n));
        chk({tag, ".full"},   DW'(full),         DW'(n == DEPTH));
        chk({tag, ".empty"},  DW'(empty),        DW'(n == 0));
        chk({tag, ".afull"},  DW'(almost_full),  DW'(n >= AF));
        chk({tag, ".aempty"}, DW'(almost_empty), DW'(n <= AE));
        chk({tag, ".wr_ack"}, DW'(wr_ack),       DW'(m_wa));
        chk({tag, ".wr_err"}, DW'(wr_err),       DW'(m_we));
        chk({tag, ".rd_ack"}, DW'(rd_ack),       DW'(m_ra));
        chk({tag, ".rd_err"}, DW'(rd_err),       DW'(m_re));
        chk({tag, ".d_out"},  d_out,             m_dout);
    endtask

    // Drive one cycle of stimulus (inputs change on the falling edge), then check after the next falling edge.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit rst, input string tag);
        wr_en = w;
        rd_en = r;
        d_in  = d;
        reset = rst;
        model(w, r, d, rst);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;
        t_wr = 1'b0; t_rd = 1'b0; t_state = 3'd0; t_cnt = '0;
        m_dout = '0; m_state = 3'd0;
        @(negedge clk);

        // Reset state.
        step(0, 0, '0, 1, "reset");

        // Fill with A0..A7.
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(32'hA0 + i), 0, "fill");
        chk("fill.af_at_full", DW'(almost_full), 32'd1);

        // Write while full, then drain in order.
        step(1, 0, 32'hDEAD_BEEF, 0, "wr_full");
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0, 0, "drain");
        chk("drain.last", d_out, 32'hA7);

        // Read while empty, then held for three cycles.
        step(0, 1, '0, 0, "rd_empty");
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0, "rd_empty_hold");

        // Preload 3, then 20 cycles of simultaneous read/write across pointer wrap.
        for (int i = 0; i < 3; i++) step(1, 0, $urandom, 0, "preload");
        for (int i = 0; i < 20; i++) step(1, 1, $urandom, 0, "rdwr");
        step(0, 0, '0, 0, "idle");

        // Simultaneous request on empty, then on full.
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0, "empty_out");
        step(1, 1, 32'h1111_0001, 0, "rdwr_empty");
        for (int i = 0; i < DEPTH - 1; i++) step(1, 0, $urandom, 0, "refill");
        step(1, 1, 32'h2222_0002, 0, "rdwr_full");

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 63) == 0), "random");
        end

        // Reset with a write pending at count 5.
        step(0, 0, '0, 1, "pre_reset");
        for (int i = 0; i < 5; i++) step(1, 0, $urandom, 0, "load5");
        step(1, 0, 32'h5555_5555, 1, "mid_reset");
        step(0, 0, '0, 0, "after_reset");

        // Unused state code decodes to INIT with no operation.
        t_state = 3'd7; t_wr = 1'b1; t_rd = 1'b1; t_cnt = 4'd3;
        #1;
        chk("ill.next",  DW'(t_next),  32'd0);
        chk("ill.do_wr", DW'(t_do_wr), 32'd0);
        chk("ill.do_rd", DW'(t_do_rd), 32'd0);
        t_rd = 1'b0; t_cnt = 4'd8;
        #1;
        chk("ill.wr_err", DW'(t_wr_err), 32'd0);
        t_wr = 1'b0; t_rd = 1'b1; t_cnt = 4'd0;
        #1;
        chk("ill.rd_err", DW'(t_rd_err), 32'd0);
        t_state = 3'd4;
        #1;
        chk("legal.rd_err", DW'(t_rd_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmac_fifo_param.md
Name: dmac_fifo_param

Overview:
Parametrised synchronous FIFO for the DMAC datapath. It is the next generation of the DMAC FIFO next-state/control logic and adds four things: configurable data width and depth, a simultaneous read+write mode (RDWR), programmable almost-full/almost-empty flags, and registered ack/error strobes. It sits between the DMAC master-side fetch engine (writer) and the slave-side store engine (reader). Storage, pointers, count and control FSM are all in one clock domain.

Parameters:
DATA_WIDTH, 32, width of d_in/d_out
DEPTH, 8, number of entries; power of two, >= 2
AW, log2(DEPTH), address width; derived, not overridden
CW, AW+1, data_count width; derived
AF_LEVEL, DEPTH-2, almost_full asserted when data_count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when data_count <= AE_LEVEL

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request
rd_en  in  1  read request
d_in  in  DATA_WIDTH  write data
d_out  out  DATA_WIDTH  read data, registered
state  out  3  current FSM state
data_count  out  CW  entries held, 0..DEPTH
full  out  1  data_count == DEPTH
empty  out  1  data_count == 0
almost_full  out  1  data_count >= AF_LEVEL
almost_empty  out  1  data_count <= AE_LEVEL
wr_ack  out  1  write accepted last cycle
wr_err  out  1  write rejected last cycle (full)
rd_ack  out  1  read performed last cycle; d_out valid
rd_err  out  1  read rejected last cycle (empty)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, and takes priority over all other activity.
- Reset values:
  - state=INIT, head=0, tail=0, data_count=0, d_out=0
  - all ack/err=0, full=0, empty=1
  - almost_empty=1, almost_full=0
  - memory contents not reset
- State encoding: INIT=0, NO_OP=1, WRITE=2, WR_ERROR=3, READ=4, RD_ERROR=5, RDWR=6. Code 7 is illegal: next_state=INIT and no operation performed.
- Next-state rule: identical from every legal state. It is a function of wr_en, rd_en and data_count only.
  - wr_en & rd_en & 0<count<DEPTH -> RDWR
  - wr_en & rd_en & count==0 -> WRITE, plus rd_err
  - wr_en & rd_en & count==DEPTH -> READ, plus wr_err
  - wr_en only: count==DEPTH -> WR_ERROR, else WRITE
  - rd_en only: count==0 -> RD_ERROR, else READ
  - neither -> NO_OP
- Operations on the edge that enters the state:
  - WRITE: mem[tail]<=d_in; tail++; count+1; wr_ack=1.
  - READ: d_out<=mem[head]; head++; count-1; rd_ack=1.
  - RDWR: both of the above; count unchanged; wr_ack=rd_ack=1.
  - WR_ERROR: wr_err=1; nothing else changes.
  - RD_ERROR: rd_err=1; nothing else changes.
  - NO_OP: no change; d_out holds its value.
- Strobes: ack/err are one-cycle registered pulses, recomputed every cycle. They stay high across consecutive qualifying cycles.
- Read latency: 1 cycle. d_out is valid in the same cycle as rd_ack and holds until the next read.
- Pointers: AW bits wide, wrap DEPTH-1 -> 0 naturally.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the registered data_count.
- Reset mid-operation: a request in the reset cycle is dropped and the FIFO is empty the next cycle.

Decomposition:
- Package dmac_fifo_pkg holds:
  - the 3-bit state constants (INIT..RDWR)
  - the parameter-derivation function clog2
- Sub-module dmac_fifo_param_ns: purely combinational next-state and operation decode.
  - Inputs: wr_en, rd_en, state, data_count.
  - Outputs: next_state, do_wr, do_rd, wr_err_n, rd_err_n.
- The top level holds the memory, pointers, count and output registers.

Test Plan:
1. Reset, then 8 single writes of 0xA0..0xA7 (DEPTH=8) -> wr_ack each cycle; count 1..8; almost_full at count 6; full=1 at count 8; state=WRITE.
2. Ninth write while full -> state=WR_ERROR, wr_err=1, count=8, memory unchanged. Then 8 reads -> d_out=0xA0..0xA7 in order with rd_ack; empty=1 after the last read.
3. Read on an empty FIFO -> state=RD_ERROR, rd_err=1, count=0, d_out holds its last value. Then a read held for 3 cycles -> rd_err stays high for all 3 cycles.
4. Preload 3 entries; assert wr_en&rd_en for 20 cycles -> state=RDWR, count stays 3; d_out matches a scoreboard across pointer wrap (tail wraps twice).
5. Corner cases:
   - wr_en&rd_en when empty -> WRITE, rd_err=1, count=1.
   - wr_en&rd_en when full -> READ, wr_err=1, count=7.
6. Reset mid-run: reset asserted with count=5 and wr_en=1 -> next cycle count=0, empty=1, state=INIT, no ack. Also force state=7 -> INIT on the next edge.
